hart_sequencer: RTL and testbench

//  Multi-cycle control FSM for one hart. Owns the PC and the single shared memory port.

---
 rtl/hart_sequencer.sv | 153 +++++++++++++++
 tb/tb_hart_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hart_sequencer.sv
// Multi-cycle fetch/exec/mem/writeback sequencer for one hart; owns the PC and the shared memory port.
// Optional HART_SEQ_MISALIGN_TRAP_EN: a taken jump to a non-word-aligned target halts the hart.

package hart_seq_pkg;
   localparam int XLEN = 32;

   typedef enum logic [3:0] {
      OP_LUI,
      OP_AUIPC,
      OP_JAL,
      OP_JALR,
      OP_BRANCH,
      OP_LOAD,
      OP_STORE,
      OP_IMM,
      OP_REG,
      OP_FENCE,
      OP_SYSTEM,
      OP_UNKNOWN
   } opcode_t;
endpackage

module hart_sequencer
   import hart_seq_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ready,
   input  logic [XLEN-1:0] mem_rdata,
   output logic [31:0]     instr_word,
   input  opcode_t         opcode,
   input  logic [XLEN-1:0] eff_addr,
   input  logic [XLEN-1:0] store_val,
   input  logic            store_enable,
   input  logic            rd_out_enable,
   input  logic            jump_enable,
   input  logic [XLEN-1:0] jump_target_addr,
   output logic [XLEN-1:0] load_val,
   output logic [XLEN-1:0] pc,
   output logic            rf_we,
   output logic            retire,
   output logic            halted
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   state_t          state, state_next;
   logic [XLEN-1:0] pc_next;
   logic            fetch_done;
   logic            load_done;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_FETCH;
         pc         <= RESET_PC;
         instr_word <= '0;
         load_val   <= '0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         if (fetch_done) instr_word <= mem_rdata;
         if (load_done)  load_val   <= mem_rdata;
      end
   end

   // NOTE: every signal gets a default first so no path through the case infers a latch.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = pc;
      mem_wdata  = '0;
      rf_we      = 1'b0;
      retire     = 1'b0;
      halted     = 1'b0;
      fetch_done = 1'b0;
      load_done  = 1'b0;

      case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               fetch_done = 1'b1;
               state_next = S_EXEC;
            end
         end

         S_EXEC: begin
            if (opcode == OP_LOAD || opcode == OP_STORE) state_next = S_MEM;
            else if (opcode == OP_UNKNOWN)               state_next = S_HALT;
            else                                          state_next = S_WB;
         end

         S_MEM: begin
            mem_req   = 1'b1;
            mem_we    = store_enable;
            mem_addr  = eff_addr;
            mem_wdata = store_val;
            if (mem_ready) begin
               load_done  = (opcode == OP_LOAD);
               state_next = S_WB;
            end
         end

         S_WB: begin
`ifdef HART_SEQ_MISALIGN_TRAP_EN
            if (jump_enable && (jump_target_addr[1:0] != 2'b00)) begin
               state_next = S_HALT;
            end else begin
               rf_we      = rd_out_enable;
               retire     = 1'b1;
               pc_next    = jump_enable ? jump_target_addr : pc + XLEN'(4);
               state_next = S_FETCH;
            end
`else
            // Low target bits are dropped so the PC stays word aligned.
            rf_we      = rd_out_enable;
            retire     = 1'b1;
            pc_next    = jump_enable ? (jump_target_addr & ~XLEN'(3)) : pc + XLEN'(4);
            state_next = S_FETCH;
`endif
         end

         S_HALT: begin
            halted = 1'b1;
         end

         default: state_next = S_FETCH;
      endcase

      // Reset abandons any outstanding transfer in the same cycle it is asserted.
      if (reset) begin
         mem_req = 1'b0;
         rf_we   = 1'b0;
         retire  = 1'b0;
      end
   end

endmodule

// File: tb/tb_hart_sequencer.sv
// Self-checking bench for hart_sequencer: a per-instruction timeline model predicts every cycle's outputs.
// Honours HART_SEQ_MISALIGN_TRAP_EN the same way as the design.

module tb_hart_sequencer;
   import hart_seq_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk;
   logic        reset;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] instr_word;
   opcode_t     opcode;
   logic [31:0] eff_addr;
   logic [31:0] store_val;
   logic        store_enable;
   logic        rd_out_enable;
   logic        jump_enable;
   logic [31:0] jump_target_addr;
   logic [31:0] load_val;
   logic [31:0] pc;
   logic        rf_we;
   logic        retire;
   logic        halted;

   hart_sequencer #(.RESET_PC(RST_PC)) dut (
      .clk              (clk),
      .reset            (reset),
      .mem_req          (mem_req),
      .mem_we           (mem_we),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_ready        (mem_ready),
      .mem_rdata        (mem_rdata),
      .instr_word       (instr_word),
      .opcode           (opcode),
      .eff_addr         (eff_addr),
      .store_val        (store_val),
      .store_enable     (store_enable),
      .rd_out_enable    (rd_out_enable),
      .jump_enable      (jump_enable),
      .jump_target_addr (jump_target_addr),
      .load_val         (load_val),
      .pc               (pc),
      .rf_we            (rf_we),
      .retire           (retire),
      .halted           (halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk_wdata;
      logic        rf_we;
      logic        retire;
      logic        halted;
      logic        chk_halt;
      logic [31:0] pc;
      logic [31:0] iw;
      logic [31:0] lv;
   } cyc_t;

   cyc_t        exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   logic [31:0] m_pc;
   logic [31:0] m_iw;
   logic [31:0] m_lv;
   logic        m_halted;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
      end
   endtask

   // Architectural view of an idle cycle; callers override what the current phase drives.
   function automatic cyc_t base();
      cyc_t e;
      e.req       = 1'b0;
      e.we        = 1'b0;
      e.addr      = '0;
      e.wdata     = '0;
      e.chk_wdata = 1'b0;
      e.rf_we     = 1'b0;
      e.retire    = 1'b0;
      e.halted    = m_halted;
      e.chk_halt  = 1'b1;
      e.pc        = m_pc;
      e.iw        = m_iw;
      e.lv        = m_lv;
      return e;
   endfunction

   task automatic step(input cyc_t e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cyc_t e;
         e = exp_q.pop_front();
         check("mem_req", 32'(mem_req), 32'(e.req));
         if (e.req) begin
            check("mem_we", 32'(mem_we), 32'(e.we));
            check("mem_addr", mem_addr, e.addr);
            if (e.chk_wdata) check("mem_wdata", mem_wdata, e.wdata);
         end
         check("rf_we", 32'(rf_we), 32'(e.rf_we));
         check("retire", 32'(retire), 32'(e.retire));
         if (e.chk_halt) check("halted", 32'(halted), 32'(e.halted));
         check("pc", pc, e.pc);
         check("instr_word", instr_word, e.iw);
         check("load_val", load_val, e.lv);
      end
   end

   task automatic model_reset();
      m_pc     = RST_PC;
      m_iw     = '0;
      m_lv     = '0;
      m_halted = 1'b0;
   endtask

   task automatic halt_and_reset(input logic [31:0] lit_pc);
      cyc_t e;
      m_halted = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mem_ready = 1'b1;
         mem_rdata = 32'hFFFF_0000;
         e = base();
         step(e);
      end
      check("halt_sticky", 32'(halted), 32'd1);
      check("halt_pc_frozen", pc, lit_pc);
      check("halt_no_req", 32'(mem_req), 32'd0);
      reset     = 1'b1;
      mem_ready = 1'b0;
      e = base();
      e.chk_halt = 1'b0;
      step(e);
      reset = 1'b0;
      model_reset();
   endtask

   // One instruction from fetch to retire with fw fetch and mw data wait states.
   task automatic run_instr(input opcode_t op, input int fw, input int mw,
                            input logic [31:0] iw, input logic [31:0] rd_data,
                            input logic [31:0] eff, input logic [31:0] sval,
                            input logic st_en, input logic rd_en, input logic j_en,
                            input logic [31:0] jt, input bit rst_in_mem,
                            input logic [31:0] lit_pc, output int cycles);
      cyc_t e;
      bit   trap;
      cycles           = 0;
      opcode           = op;
      eff_addr         = eff;
      store_val        = sval;
      store_enable     = st_en;
      rd_out_enable    = rd_en;
      jump_enable      = j_en;
      jump_target_addr = jt;

      for (int c = 0; c <= fw; c++) begin
         mem_ready = (c == fw);
         mem_rdata = (c == fw) ? iw : ~iw;
         e = base();
         e.req  = 1'b1;
         e.addr = m_pc;
         step(e);
         cycles++;
      end
      m_iw = iw;

      mem_ready = 1'b1;
      mem_rdata = 32'hBAD0_BAD0;
      e = base();
      step(e);
      cycles++;

      if (op == OP_UNKNOWN) begin
         halt_and_reset(lit_pc);
         return;
      end

      if (op == OP_LOAD || op == OP_STORE) begin
         for (int m = 0; m <= mw; m++) begin
            if (rst_in_mem && m == 1) begin
               reset     = 1'b1;
               mem_ready = 1'b0;
               e = base();
               step(e);
               reset = 1'b0;
               model_reset();
               return;
            end
            mem_ready = (m == mw);
            mem_rdata = (m == mw) ? rd_data : 32'h5A5A_5A5A;
            e = base();
            e.req       = 1'b1;
            e.we        = st_en;
            e.addr      = eff;
            e.wdata     = sval;
            e.chk_wdata = st_en;
            step(e);
            cycles++;
         end
         if (op == OP_LOAD) m_lv = rd_data;
      end

      mem_ready = 1'b1;
      mem_rdata = 32'h0BAD_0BAD;
      trap = 1'b0;
`ifdef HART_SEQ_MISALIGN_TRAP_EN
      trap = j_en && (jt[1:0] != 2'b00);
`endif
      e = base();
      e.rf_we  = rd_en && !trap;
      e.retire = !trap;
      step(e);
      cycles++;
      if (trap) begin
         halt_and_reset(lit_pc);
         return;
      end
      m_pc      = j_en ? (jt & 32'hFFFF_FFFC) : m_pc + 32'd4;
      mem_ready = 1'b0;
   endtask

   initial begin
      int   cyc;
      cyc_t e;
      reset            = 1'b1;
      mem_ready        = 1'b0;
      mem_rdata        = '0;
      opcode           = OP_IMM;
      eff_addr         = '0;
      store_val        = '0;
      store_enable     = 1'b0;
      rd_out_enable    = 1'b0;
      jump_enable      = 1'b0;
      jump_target_addr = '0;
      model_reset();

      @(posedge clk);
      #1;
      mem_ready = 1'b1;
      e = base();
      step(e);
      reset     = 1'b0;
      mem_ready = 1'b0;

      // ADDI, zero wait states
      run_instr(OP_IMM, 0, 0, 32'h0050_0093, 0, 0, 0, 0, 1, 0, 0, 0, 0, cyc);
      check("addi_latency", cyc, 32'd3);
      check("addi_next_pc", pc, 32'h0000_0104);

      // ADDI with four fetch wait states
      run_instr(OP_IMM, 4, 0, 32'h0010_8113, 0, 0, 0, 0, 1, 0, 0, 0, 0, cyc);
      check("fetch_wait_latency", cyc, 32'd7);
      check("fetch_wait_iw", instr_word, 32'h0010_8113);

      // LW from 0x200
      run_instr(OP_LOAD, 0, 0, 32'h2000_2183, 32'hDEAD_BEEF, 32'h200, 0, 0, 1, 0, 0, 0, 0, cyc);
      check("lw_latency", cyc, 32'd4);
      check("lw_load_val", load_val, 32'hDEAD_BEEF);

      // SW to 0x204 with two data wait states
      run_instr(OP_STORE, 0, 2, 32'h2030_2223, 0, 32'h204, 32'd15, 1, 0, 0, 0, 0, 0, cyc);
      check("sw_latency", cyc, 32'd6);
      check("sw_next_pc", pc, 32'h0000_0110);

      // JAL to 0x1A8 then not-taken BEQ
      run_instr(OP_JAL, 0, 0, 32'h0980_00EF, 0, 0, 0, 0, 1, 1, 32'h1A8, 0, 0, cyc);
      check("jal_target_pc", pc, 32'h0000_01A8);
      run_instr(OP_BRANCH, 0, 0, 32'h0020_8463, 0, 0, 0, 0, 0, 0, 32'h1B0, 0, 0, cyc);
      check("beq_nt_pc", pc, 32'h0000_01AC);

      // PC wraps past the top of the address space
      run_instr(OP_JAL, 0, 0, 32'h0000_006F, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, cyc);
      run_instr(OP_IMM, 0, 0, 32'h0000_0013, 0, 0, 0, 0, 1, 0, 0, 0, 0, cyc);
      check("pc_wrap", pc, 32'h0000_0000);

      // Reset while a load is waiting for memory
      run_instr(OP_LOAD, 0, 3, 32'h3000_2283, 32'h1234_5678, 32'h300, 0, 0, 1, 0, 0, 1, 0, cyc);
      check("mid_mem_reset_pc", pc, RST_PC);
      check("mid_mem_reset_lv", load_val, 32'h0);
      check("mid_mem_reset_iw", instr_word, 32'h0);

      // Misaligned jump target
      run_instr(OP_JALR, 0, 0, 32'h0000_8067, 0, 0, 0, 0, 1, 1, 32'h1AA, 0, 32'h100, cyc);
`ifdef HART_SEQ_MISALIGN_TRAP_EN
      check("misalign_trap_pc", pc, RST_PC);
`else
      check("misalign_align_pc", pc, 32'h0000_01A8);
`endif

      // Unknown opcode halts until reset
      run_instr(OP_UNKNOWN, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 1, 0, 0, 0, m_pc, cyc);
      run_instr(OP_IMM, 0, 0, 32'h0000_0013, 0, 0, 0, 0, 0, 0, 0, 0, 0, cyc);
      check("after_halt_pc", pc, 32'h0000_0104);

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
